mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle CPU. It is the target side of the CPU's single memory port: it accepts one word read or write per request, performs it against an internal synchronous RAM or the memory-mapped register window, and returns a one-cycle `ready` pulse with read data. Each access is a fixed 3-state handshake, so the control unit's fetch and memory states can stall on `ready`.

---
 rtl/mem_if.sv | 23 ++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Memory port between the multicycle CPU (master) and mem_responder (slave).
// Handshake: master raises req with we/addr/wdata stable while the slave is idle;
// the slave answers each accepted request with exactly one single-cycle ready pulse.
interface mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified memory responder: fixed IDLE -> ACCESS -> RESPOND handshake over RAM and
// an optional register window enabled by MEM_RESPONDER_MMIO_EN.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic       clk,
  input  logic       reset,
  mem_if.slave       bus,
  output logic [7:0] leds,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        busy_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] ram [2**DEPTH_LOG2];

  logic                  aligned;
  logic                  hit_ram;
  logic                  hit_led;
  logic                  hit_cnt;
  logic                  hit_est;
  logic                  bad;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;

`ifdef MEM_RESPONDER_MMIO_EN
  logic [7:0]  led_q;
  logic [31:0] cycle_cnt;
`endif

  assign aligned = (addr_q[1:0] == 2'b00);
  assign idx     = addr_q[DEPTH_LOG2+1:2];
  assign hit_ram = aligned && (addr_q[31:DEPTH_LOG2+2] == '0);

  always_comb begin
    hit_led = 1'b0;
    hit_cnt = 1'b0;
    hit_est = 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
    hit_led = (addr_q == 32'hFFFF_0000);
    hit_cnt = (addr_q == 32'hFFFF_0004);
    hit_est = (addr_q == 32'hFFFF_0008);
`endif
  end

  // Misaligned addresses never match the register window, so one flag covers both faults.
  assign bad = !(hit_ram || hit_led || hit_cnt || hit_est);

  always_comb begin
    rd_word = 32'h0;
    if (hit_ram) begin
      rd_word = ram[idx];
    end
`ifdef MEM_RESPONDER_MMIO_EN
    else if (hit_led) begin
      rd_word = {24'h0, led_q};
    end else if (hit_cnt) begin
      rd_word = cycle_cnt;
    end else if (hit_est) begin
      rd_word = {31'h0, err_q};
    end
`endif
  end

  // RAM array has no reset; a reset during ACCESS blocks the pending write.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && we_q && hit_ram) begin
      ram[idx] <= wdata_q;
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
      led_q   <= 8'h0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          ready_q <= 1'b1;
          state   <= RESPOND;
          if (bad) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else if (we_q) begin
            rdata_q <= 32'h0;
`ifdef MEM_RESPONDER_MMIO_EN
            if (hit_led) begin
              led_q <= wdata_q[7:0];
            end
            if (hit_est) begin
              err_q <= 1'b0;
            end
`endif
          end else begin
            rdata_q <= rd_word;
          end
        end
        RESPOND: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign fsm_state = state;

`ifdef MEM_RESPONDER_MMIO_EN
  assign leds = led_q;
`else
  assign leds = 8'h0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized accesses
// checked against an address-map level reference model.
module tb_mem_responder;
  localparam int DEPTH_LOG2 = 8;
  localparam int WORDS      = 2**DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds;
  logic [1:0] fsm_state;

  mem_if bus ();

  mem_responder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .leds      (leds),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] mem_m [WORDS];
  bit          known_m [WORDS];
  bit          err_m = 1'b0;
  logic [7:0]  leds_m = 8'h0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns 1 when the response data is predictable; updates the model state.
  function automatic bit ref_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                    output logic [31:0] exp_rd);
    int i;
    exp_rd = 32'h0;
    if (a[1:0] != 2'b00) begin
      err_m = 1'b1;
      return 1'b1;
    end
    if (a < 32'(4 * WORDS)) begin
      i = int'(a / 4);
      if (w) begin
        mem_m[i]   = d;
        known_m[i] = 1'b1;
        return 1'b0;
      end
      exp_rd = mem_m[i];
      return known_m[i];
    end
`ifdef MEM_RESPONDER_MMIO_EN
    if (a == 32'hFFFF_0000) begin
      if (w) begin
        leds_m = d[7:0];
        return 1'b0;
      end
      exp_rd = {24'h0, leds_m};
      return 1'b1;
    end
    if (a == 32'hFFFF_0004) begin
      return 1'b0;
    end
    if (a == 32'hFFFF_0008) begin
      if (w) begin
        err_m = 1'b0;
        return 1'b0;
      end
      exp_rd = {31'h0, err_m};
      return 1'b1;
    end
`endif
    err_m = 1'b1;
    return 1'b1;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the following idle negedge.
  task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err_obs);
    int lat = 0;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    rd        = 32'h0;
    err_obs   = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 1'b0;
      if (bus.ready) begin
        lat     = k;
        rd      = bus.rdata;
        err_obs = bus.err;
      end
    end
    check("latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("idle_busy", {31'h0, bus.busy}, 32'h0);
    check("ready_pulse_width", {31'h0, bus.ready}, 32'h0);
  endtask

  task automatic access_and_check(input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e;
    logic [31:0] rd;
    logic        eo;
    bit          pred;
    pred = ref_access(w, a, d, e);
    if (pred) exp_q.push_back(e);
    do_access(w, a, d, rd, eo);
    if (pred) check("rdata", rd, exp_q.pop_front());
    check("err", {31'h0, eo}, {31'h0, err_m});
    check("leds", {24'h0, leds}, {24'h0, leds_m});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd1, rd2, e;
    logic        eo;
    int          pulses;
    bit          pred;

    foreach (known_m[i]) known_m[i] = 1'b0;
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.ready}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_leds", {24'h0, leds}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read back, then a misaligned read and a later valid read
    access_and_check(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access_and_check(1'b0, 32'h0000_0010, 32'h0);
    access_and_check(1'b0, 32'h0000_0002, 32'h0);
    access_and_check(1'b0, 32'h0000_0010, 32'h0);

    // Unmapped read just past the RAM must leave word 0 alone
    access_and_check(1'b1, 32'h0000_0000, 32'h1111_0000);
    access_and_check(1'b0, 32'h0000_0400, 32'h0);
    access_and_check(1'b0, 32'h0000_0000, 32'h0);

    // Continuous req: three reads back to back
    access_and_check(1'b1, 32'h0000_0004, 32'h2222_0004);
    access_and_check(1'b1, 32'h0000_0008, 32'h3333_0008);
    for (int j = 0; j < 3; j++) begin
      pred = ref_access(1'b0, 32'(4 * j), 32'h0, e);
      exp_q.push_back(e);
    end
    pulses    = 0;
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("hold_busy", {31'h0, bus.busy}, {31'h0, ((i % 3) != 0)});
      check("hold_ready", {31'h0, bus.ready}, {31'h0, ((i % 3) == 2)});
      if (bus.ready) begin
        pulses++;
        if (exp_q.size() > 0) check("hold_rdata", bus.rdata, exp_q.pop_front());
        bus.addr = 32'(4 * pulses);
      end
      if (i == 9) bus.req = 1'b0;
    end
    check("hold_pulses", 32'(pulses), 32'd3);
    exp_q.delete();

    // Reset during ACCESS aborts the write with no response
    access_and_check(1'b1, 32'h0000_0020, 32'h5555_AAAA);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h0000_0020;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.req = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    err_m   = 1'b0;
    leds_m  = 8'h0;
    pulses  = int'(bus.ready);
    repeat (3) begin
      @(negedge clk);
      pulses += int'(bus.ready);
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    check("abort_err", {31'h0, bus.err}, 32'h0);
    access_and_check(1'b0, 32'h0000_0020, 32'h0);

`ifdef MEM_RESPONDER_MMIO_EN
    access_and_check(1'b1, 32'hFFFF_0000, 32'h0000_00A5);
    check("leds_a5", {24'h0, leds}, 32'h0000_00A5);
    do_access(1'b0, 32'hFFFF_0004, 32'h0, rd1, eo);
    do_access(1'b0, 32'hFFFF_0004, 32'h0, rd2, eo);
    check("cnt_delta", rd2 - rd1, 32'd3);
    access_and_check(1'b1, 32'hFFFF_0000, 32'h0000_0000);
    access_and_check(1'b0, 32'h0000_0001, 32'h0);
    access_and_check(1'b0, 32'hFFFF_0008, 32'h0);
    access_and_check(1'b1, 32'hFFFF_0008, 32'h0);
    check("err_cleared", {31'h0, bus.err}, 32'h0);
`else
    access_and_check(1'b1, 32'hFFFF_0000, 32'h0000_00A5);
    access_and_check(1'b0, 32'hFFFF_0004, 32'h0);
    access_and_check(1'b0, 32'hFFFF_0008, 32'h0);
`endif

    // Randomized traffic over a small RAM window, faults and the register window
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      kind = $urandom_range(0, 5);
      d    = $urandom;
      a    = 32'(4 * $urandom_range(0, 15));
      case (kind)
        0, 1: access_and_check(1'b1, a, d);
        2, 3: access_and_check(1'b0, a, d);
        4:    access_and_check($urandom_range(0, 1) == 1, a + 32'($urandom_range(1, 3)), d);
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h0000_0400 + 32'(4 * $urandom_range(0, 255));
            1:       a = 32'hFFFF_0000;
            2:       a = 32'hFFFF_0008;
            default: a = 32'h8000_0000;
          endcase
          access_and_check($urandom_range(0, 1) == 1, a, d);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
